sample_packetizer: RTL and testbench
====================================

SAMPLE_PACKETIZER -- requirements
Module: sample_packetizer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of one sample word; values below 32 are not supported.
REQ-002 SHALL have parameter N_CHANNELS, default 2: number of samples in one input frame (1..8).
REQ-003 SHALL have parameter FIFO_DEPTH, default 256: buffer depth in words; must be a power of 2 and at least MAX_PAYLOAD_WORDS.
REQ-004 SHALL have parameter MAX_PAYLOAD_WORDS, default 128: upper limit on payload words per packet.
REQ-005 SHALL have parameter SEQ_HEADER, default 1: when 1, one header word is sent before each payload.
REQ-006 SHALL have these ports, in this order:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous reset, active-low.
- s_sample_data  in  N_CHANNELS*DATA_WIDTH  input frame; channel 0 is in the LSBs.
- s_sample_valid  in  1  one-cycle frame strobe.
- cfg_enable  in  1  permits new packets to start.
- cfg_payload_words  in  clog2(MAX_PAYLOAD_WORDS+1)  payload length in words.
- m_axis_tdata  out  DATA_WIDTH  output stream data.
- m_axis_tvalid  out  1  output stream valid.
- m_axis_tready  in  1  output stream ready.
- m_axis_tlast  out  1  marks the last payload word.
- drop_count  out  16  frames dropped, saturating.
- fifo_level  out  clog2(FIFO_DEPTH+1)  words currently stored.

Function
REQ-007 SHALL accept a frame on s_sample_valid only if the serializer is idle and free space is at least N_CHANNELS; otherwise the whole frame SHALL be dropped.
REQ-008 SHALL register an accepted frame, then write channels 0..N_CHANNELS-1 into the FIFO, one word per cycle, over the N_CHANNELS cycles that follow acceptance.
REQ-009 SHALL treat a strobe that arrives while the serializer is busy as a dropped frame; frame strobes must be spaced at least N_CHANNELS+1 cycles apart.
REQ-010 SHALL increment drop_count by 1 per dropped frame, saturating at 0xFFFF; no partial frame SHALL ever be written.
REQ-011 SHALL show a word written in cycle k in fifo_level from cycle k+1; a simultaneous FIFO read and write SHALL leave the level unchanged.
REQ-012 SHALL implement an output FSM with states IDLE, HEADER and PAYLOAD.
REQ-013 IDLE SHALL move on when cfg_enable=1 and fifo_level >= L; this ensures a started packet never underruns.
REQ-014 IDLE SHALL go to HEADER when SEQ_HEADER=1 and to PAYLOAD when SEQ_HEADER=0.
REQ-015 SHALL latch L on leaving IDLE, as follows:
- L = cfg_payload_words.
- A value of 0 is treated as 1.
- Values above MAX_PAYLOAD_WORDS are clamped to MAX_PAYLOAD_WORDS.
REQ-016 SHALL assert m_axis_tvalid no later than 2 cycles after the IDLE exit condition becomes true.
REQ-017 HEADER SHALL present tdata = {zeros, seq_num[15:0], drop_count[15:0]} with tlast=0, and SHALL go to PAYLOAD on handshake.
REQ-018 PAYLOAD SHALL present L FIFO words in write order and SHALL assert tlast only on word L.
REQ-019 After the tlast handshake the FSM SHALL return to IDLE and seq_num SHALL increment, wrapping 0xFFFF->0x0000.
REQ-020 SHALL hold tdata, tlast and tvalid stable while tvalid=1 and tready=0, and SHALL never deassert tvalid without a handshake.
REQ-021 SHALL allow one word per cycle when tready stays high, with no bubbles inside a packet.
REQ-022 SHALL always complete an in-flight packet; deasserting cfg_enable or changing cfg_payload_words mid-packet SHALL only affect the next packet.
REQ-023 SHALL sample drop_count for the header in the HEADER cycle that holds the first tvalid.
REQ-024 SHALL keep accepting input while a packet is being sent, subject to the free-space rule.

Reset
REQ-025 On rst_n=0 at a clk edge the following SHALL hold:
- FIFO emptied; fifo_level=0.
- Serializer idle.
- FSM in IDLE.
- seq_num=0, drop_count=0.
- m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0.
REQ-026 A reset mid-packet SHALL abandon the packet, with no further tvalid until a new threshold is met after reset.

Verification
REQ-027 Packet with header. Setup: N_CHANNELS=2, L=4, tready=1, enable=1. Stimulus: frames {A1,A0} then {B1,B0}. Required: tdata 0x00000000, A0, A1, B0, B1, with tlast on B1. The next packet's header is 0x00010000.
REQ-028 Backpressure. Stimulus: tready low for 3 cycles during word A1. Required: tdata=A1, tvalid=1 and tlast=0 are held; the stream resumes with B0 in the cycle after tready rises.
REQ-029 FIFO full. Setup: FIFO_DEPTH=8, tready=0, enable=0. Stimulus: 5 frames. Required: 4 frames accepted, fifo_level=8, drop_count=1. After enable with L=8, the header is 0x00000001.
REQ-030 Busy serializer. Stimulus: strobes on cycles t and t+1 with N_CHANNELS=2. Required: the second frame is dropped, drop_count=1, fifo_level=2.
REQ-031 Mid-packet changes. Stimulus: L=4 packet in flight; change cfg_payload_words to 2 and drop enable for one cycle. Required: the current packet ends after 4 words; the next packet has 2 words.
REQ-032 Reset mid-packet. Stimulus: rst_n low for 1 cycle after 2 payload words. Required: the next cycle shows tvalid=0, fifo_level=0 and seq_num=0; the next header is 0x00000000.

Source files
------------

// File: rtl/sample_packetizer.sv
// Sample packetizer: frames of N_CHANNELS samples are serialized into a word FIFO
// and streamed out as AXI-Stream packets, optionally led by a sequence/drop header.
module sample_packetizer #(
   parameter int unsigned DATA_WIDTH        = 32,
   parameter int unsigned N_CHANNELS        = 2,
   parameter int unsigned FIFO_DEPTH        = 256,
   parameter int unsigned MAX_PAYLOAD_WORDS = 128,
   parameter int unsigned SEQ_HEADER        = 1
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic [N_CHANNELS*DATA_WIDTH-1:0]       s_sample_data,
   input  logic                                   s_sample_valid,
   input  logic                                   cfg_enable,
   input  logic [$clog2(MAX_PAYLOAD_WORDS+1)-1:0] cfg_payload_words,
   output logic [DATA_WIDTH-1:0]                  m_axis_tdata,
   output logic                                   m_axis_tvalid,
   input  logic                                   m_axis_tready,
   output logic                                   m_axis_tlast,
   output logic [15:0]                            drop_count,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]        fifo_level
);
   localparam int unsigned PW = $clog2(MAX_PAYLOAD_WORDS + 1);
   localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned IW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;
   localparam logic [LW-1:0] ACCEPT_MAX = LW'(FIFO_DEPTH - N_CHANNELS);
   localparam logic [PW-1:0] MAX_LEN    = PW'(MAX_PAYLOAD_WORDS);
   localparam logic [IW-1:0] LAST_CH    = IW'(N_CHANNELS - 1);

   typedef enum logic [1:0] {StIdle, StHeader, StPayload} state_e;

   logic [N_CHANNELS*DATA_WIDTH-1:0] frame_q;
   logic                             ser_busy_q;
   logic [IW-1:0]                    ser_idx_q;
   logic                             accept;
   logic [15:0]                      drop_q, drop_d;

   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
   logic [LW-1:0]         level_q;
   logic                  wr_en, rd_en;
   logic [DATA_WIDTH-1:0] wr_data;

   state_e        state_q, state_d;
   logic [PW-1:0] len_q, len_d, cnt_q, cnt_d, cfg_len;
   logic [15:0]   seq_q, seq_d;
   logic [31:0]   hdr_q, hdr_d;
   logic          last;

   // Frames are taken only while the serializer is idle, so no partial frame is written.
   assign accept  = s_sample_valid && !ser_busy_q && (level_q <= ACCEPT_MAX);
   assign wr_en   = ser_busy_q;
   assign wr_data = frame_q[int'(ser_idx_q)*DATA_WIDTH +: DATA_WIDTH];

   always_comb begin
      drop_d = drop_q;
      if (s_sample_valid && !accept && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         frame_q    <= '0;
         ser_busy_q <= 1'b0;
         ser_idx_q  <= '0;
         drop_q     <= '0;
      end else begin
         drop_q <= drop_d;
         if (accept) begin
            frame_q    <= s_sample_data;
            ser_busy_q <= 1'b1;
            ser_idx_q  <= '0;
         end else if (ser_busy_q) begin
            ser_idx_q <= ser_idx_q + 1'b1;
            if (ser_idx_q == LAST_CH) ser_busy_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr_q] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
         if (wr_en && !rd_en)      level_q <= level_q + 1'b1;
         else if (rd_en && !wr_en) level_q <= level_q - 1'b1;
      end
   end

   always_comb begin
      cfg_len = cfg_payload_words;
      if (cfg_payload_words == '0)        cfg_len = PW'(1);
      else if (cfg_payload_words > MAX_LEN) cfg_len = MAX_LEN;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= StIdle;
         len_q   <= '0;
         cnt_q   <= '0;
         seq_q   <= '0;
         hdr_q   <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         seq_q   <= seq_d;
         hdr_q   <= hdr_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      len_d         = len_q;
      cnt_d         = cnt_q;
      seq_d         = seq_q;
      hdr_d         = hdr_q;
      rd_en         = 1'b0;
      last          = 1'b0;
      m_axis_tvalid = 1'b0;
      m_axis_tlast  = 1'b0;
      m_axis_tdata  = '0;
      unique case (state_q)
         StIdle: begin
            // Waiting for a full packet's worth of words means payload can never underrun.
            if (cfg_enable && (level_q >= LW'(cfg_len))) begin
               len_d   = cfg_len;
               cnt_d   = '0;
               hdr_d   = {seq_q, drop_d};
               state_d = (SEQ_HEADER != 0) ? StHeader : StPayload;
            end
         end
         StHeader: begin
            m_axis_tvalid = 1'b1;
            m_axis_tdata  = DATA_WIDTH'(hdr_q);
            if (m_axis_tready) state_d = StPayload;
         end
         StPayload: begin
            last          = (cnt_q == (len_q - 1'b1));
            m_axis_tvalid = 1'b1;
            m_axis_tlast  = last;
            m_axis_tdata  = mem[rd_ptr_q];
            if (m_axis_tready) begin
               rd_en = 1'b1;
               cnt_d = cnt_q + 1'b1;
               if (last) begin
                  state_d = StIdle;
                  seq_d   = seq_q + 16'd1;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign drop_count = drop_q;
   assign fifo_level = level_q;

endmodule

// File: tb/tb_sample_packetizer.sv
// Bench for sample_packetizer: directed scenarios plus a randomized run checked
// against a queue-based reference model of the packet stream.
module tb_sample_packetizer;
   localparam int DW    = 32;
   localparam int NCH   = 2;
   localparam int DEPTH = 8;
   localparam int MAXP  = 8;
   localparam int PW    = $clog2(MAXP + 1);
   localparam int LW    = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NCH*DW-1:0] s_sample_data;
   logic              s_sample_valid;
   logic              cfg_enable;
   logic [PW-1:0]     cfg_payload_words;
   logic [DW-1:0]     m_axis_tdata;
   logic              m_axis_tvalid;
   logic              m_axis_tready;
   logic              m_axis_tlast;
   logic [15:0]       drop_count;
   logic [LW-1:0]     fifo_level;

   int n_pass  = 0;
   int n_total = 0;

   logic [31:0] cap_data [16];
   logic        cap_last [16];
   int          cap_n;

   always #5 clk = ~clk;

   sample_packetizer #(
      .DATA_WIDTH       (DW),
      .N_CHANNELS       (NCH),
      .FIFO_DEPTH       (DEPTH),
      .MAX_PAYLOAD_WORDS(MAXP),
      .SEQ_HEADER       (1)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .s_sample_data    (s_sample_data),
      .s_sample_valid   (s_sample_valid),
      .cfg_enable       (cfg_enable),
      .cfg_payload_words(cfg_payload_words),
      .m_axis_tdata     (m_axis_tdata),
      .m_axis_tvalid    (m_axis_tvalid),
      .m_axis_tready    (m_axis_tready),
      .m_axis_tlast     (m_axis_tlast),
      .drop_count       (drop_count),
      .fifo_level       (fifo_level)
   );

   function automatic int clamp_len(input int c);
      if (c == 0) return 1;
      if (c > MAXP) return MAXP;
      return c;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; s_sample_valid = 1'b0; m_axis_tready = 1'b0;
      cfg_enable = 1'b0; cfg_payload_words = PW'(4);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One strobe, then idle long enough for the serializer to finish.
   task automatic send_frame(input logic [31:0] d0, input logic [31:0] d1);
      s_sample_data = {d1, d0}; s_sample_valid = 1'b1;
      @(negedge clk);
      s_sample_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
   endtask

   task automatic capture(input int n);
      cap_n = 0;
      m_axis_tready = 1'b1;
      for (int cyc = 0; cyc < 200 && cap_n < n; cyc++) begin
         if (m_axis_tvalid) begin
            cap_data[cap_n] = m_axis_tdata; cap_last[cap_n] = m_axis_tlast; cap_n++;
         end
         @(negedge clk);
      end
      m_axis_tready = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_total++; if (m_axis_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", m_axis_tvalid); else n_pass++;
      n_total++; if (m_axis_tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", m_axis_tlast); else n_pass++;
      n_total++; if (m_axis_tdata !== 32'h0) $display("FAIL reset_tdata: got %h want 0", m_axis_tdata); else n_pass++;
      n_total++; if (fifo_level !== LW'(0)) $display("FAIL reset_level: got %0d want 0", fifo_level); else n_pass++;
      n_total++; if (drop_count !== 16'h0) $display("FAIL reset_drop: got %0d want 0", drop_count); else n_pass++;
   endtask

   task automatic test_header_packet();
      logic [31:0] exp [5];
      exp[0] = 32'h0;
      for (int i = 1; i < 5; i++) exp[i] = $urandom();
      do_reset();
      cfg_enable = 1'b1; cfg_payload_words = PW'(4);
      send_frame(exp[1], exp[2]);
      send_frame(exp[3], exp[4]);
      capture(5);
      n_total++; if (cap_n !== 5) $display("FAIL hdrpkt_count: got %0d want 5", cap_n); else n_pass++;
      for (int i = 0; i < cap_n; i++) begin
         n_total++;
         if (cap_data[i] !== exp[i]) $display("FAIL hdrpkt_data%0d: got %h want %h", i, cap_data[i], exp[i]);
         else n_pass++;
         n_total++;
         if (cap_last[i] !== (i == 4)) $display("FAIL hdrpkt_last%0d: got %b want %b", i, cap_last[i], i == 4);
         else n_pass++;
      end
   endtask

   // Continues from the previous packet, so the header carries seq 1.
   task automatic test_backpressure();
      logic [31:0] w [4];
      logic [31:0] got [2];
      int hs;
      for (int i = 0; i < 4; i++) w[i] = $urandom();
      cfg_enable = 1'b1; cfg_payload_words = PW'(4);
      send_frame(w[0], w[1]);
      send_frame(w[2], w[3]);
      hs = 0;
      for (int cyc = 0; cyc < 100 && hs < 2; cyc++) begin
         m_axis_tready = 1'b1;
         if (m_axis_tvalid) begin got[hs] = m_axis_tdata; hs++; end
         @(negedge clk);
      end
      m_axis_tready = 1'b0;
      n_total++; if (hs !== 2) $display("FAIL bp_start: got %0d handshakes want 2", hs); else n_pass++;
      n_total++; if (got[0] !== 32'h0001_0000) $display("FAIL bp_header: got %h want 00010000", got[0]); else n_pass++;
      n_total++; if (got[1] !== w[0]) $display("FAIL bp_word0: got %h want %h", got[1], w[0]); else n_pass++;
      for (int s = 0; s < 3; s++) begin
         n_total++;
         if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== w[1] || m_axis_tlast !== 1'b0)
            $display("FAIL bp_hold%0d: got v=%b d=%h l=%b want v=1 d=%h l=0", s, m_axis_tvalid,
                     m_axis_tdata, m_axis_tlast, w[1]);
         else n_pass++;
         @(negedge clk);
      end
      m_axis_tready = 1'b1;
      n_total++; if (m_axis_tdata !== w[1]) $display("FAIL bp_release: got %h want %h", m_axis_tdata, w[1]); else n_pass++;
      @(negedge clk);
      n_total++;
      if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== w[2])
         $display("FAIL bp_resume: got v=%b d=%h want v=1 d=%h", m_axis_tvalid, m_axis_tdata, w[2]);
      else n_pass++;
      @(negedge clk);
      n_total++;
      if (m_axis_tdata !== w[3] || m_axis_tlast !== 1'b1)
         $display("FAIL bp_last: got d=%h l=%b want d=%h l=1", m_axis_tdata, m_axis_tlast, w[3]);
      else n_pass++;
      @(negedge clk);
      m_axis_tready = 1'b0;
   endtask

   task automatic test_fifo_full();
      logic [31:0] w [10];
      for (int i = 0; i < 10; i++) w[i] = $urandom();
      do_reset();
      cfg_payload_words = PW'(15);
      for (int f = 0; f < 5; f++) send_frame(w[2*f], w[2*f+1]);
      n_total++; if (fifo_level !== LW'(8)) $display("FAIL full_level: got %0d want 8", fifo_level); else n_pass++;
      n_total++; if (drop_count !== 16'd1) $display("FAIL full_drop: got %0d want 1", drop_count); else n_pass++;
      cfg_enable = 1'b1;
      capture(9);
      n_total++; if (cap_n !== 9) $display("FAIL full_count: got %0d want 9", cap_n); else n_pass++;
      n_total++; if (cap_data[0] !== 32'h1) $display("FAIL full_header: got %h want 00000001", cap_data[0]); else n_pass++;
      for (int i = 1; i < cap_n; i++) begin
         n_total++;
         if (cap_data[i] !== w[i-1] || cap_last[i] !== (i == 8))
            $display("FAIL full_word%0d: got d=%h l=%b want d=%h l=%b", i, cap_data[i], cap_last[i],
                     w[i-1], i == 8);
         else n_pass++;
      end
      n_total++; if (fifo_level !== LW'(0)) $display("FAIL full_drain: got %0d want 0", fifo_level); else n_pass++;
   endtask

   task automatic test_min_length();
      logic [31:0] g0, g1;
      g0 = $urandom(); g1 = $urandom();
      do_reset();
      cfg_payload_words = PW'(0);
      send_frame(g0, g1);
      cfg_enable = 1'b1;
      capture(4);
      n_total++; if (cap_n !== 4) $display("FAIL minlen_count: got %0d want 4", cap_n); else n_pass++;
      n_total++;
      if (cap_data[0] !== 32'h0 || cap_data[1] !== g0 || cap_last[1] !== 1'b1)
         $display("FAIL minlen_pkt0: got %h %h l=%b want 00000000 %h l=1", cap_data[0], cap_data[1],
                  cap_last[1], g0);
      else n_pass++;
      n_total++;
      if (cap_data[2] !== 32'h0001_0000 || cap_data[3] !== g1 || cap_last[3] !== 1'b1)
         $display("FAIL minlen_pkt1: got %h %h l=%b want 00010000 %h l=1", cap_data[2], cap_data[3],
                  cap_last[3], g1);
      else n_pass++;
   endtask

   task automatic test_busy();
      logic [31:0] h0, h1;
      h0 = $urandom(); h1 = $urandom();
      do_reset();
      s_sample_data = {h1, h0}; s_sample_valid = 1'b1;
      @(negedge clk);
      s_sample_data = {~h1, ~h0};
      @(negedge clk);
      s_sample_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_total++; if (drop_count !== 16'd1) $display("FAIL busy_drop: got %0d want 1", drop_count); else n_pass++;
      n_total++; if (fifo_level !== LW'(2)) $display("FAIL busy_level: got %0d want 2", fifo_level); else n_pass++;
      cfg_payload_words = PW'(2); cfg_enable = 1'b1;
      capture(3);
      n_total++;
      if (cap_n !== 3 || cap_data[0] !== 32'h1 || cap_data[1] !== h0 || cap_data[2] !== h1)
         $display("FAIL busy_pkt: got n=%0d %h %h %h want n=3 00000001 %h %h", cap_n, cap_data[0],
                  cap_data[1], cap_data[2], h0, h1);
      else n_pass++;
   endtask

   task automatic test_midpacket();
      logic [31:0] k [6];
      logic [31:0] exp [8];
      logic        explast [8];
      int          hs;
      int          restore;
      for (int i = 0; i < 6; i++) k[i] = $urandom();
      exp = '{32'h0, k[0], k[1], k[2], k[3], 32'h0001_0000, k[4], k[5]};
      explast = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      do_reset();
      cfg_payload_words = PW'(4);
      for (int f = 0; f < 3; f++) send_frame(k[2*f], k[2*f+1]);
      cfg_enable = 1'b1; m_axis_tready = 1'b1;
      hs = 0; restore = -1;
      for (int cyc = 0; cyc < 200 && hs < 8; cyc++) begin
         if (cyc == restore) cfg_enable = 1'b1;
         if (hs == 2 && restore < 0) begin
            cfg_payload_words = PW'(2); cfg_enable = 1'b0; restore = cyc + 1;
         end
         if (m_axis_tvalid) begin cap_data[hs] = m_axis_tdata; cap_last[hs] = m_axis_tlast; hs++; end
         @(negedge clk);
      end
      m_axis_tready = 1'b0;
      n_total++; if (hs !== 8) $display("FAIL mid_count: got %0d want 8", hs); else n_pass++;
      for (int i = 0; i < hs; i++) begin
         n_total++;
         if (cap_data[i] !== exp[i] || cap_last[i] !== explast[i])
            $display("FAIL mid_word%0d: got d=%h l=%b want d=%h l=%b", i, cap_data[i], cap_last[i],
                     exp[i], explast[i]);
         else n_pass++;
      end
   endtask

   task automatic test_reset_midpacket();
      logic [31:0] w [4];
      int hs;
      for (int i = 0; i < 4; i++) w[i] = $urandom();
      do_reset();
      cfg_payload_words = PW'(4);
      send_frame(w[0], w[1]);
      send_frame(w[2], w[3]);
      cfg_enable = 1'b1; m_axis_tready = 1'b1;
      hs = 0;
      for (int cyc = 0; cyc < 100 && hs < 3; cyc++) begin
         if (m_axis_tvalid) hs++;
         @(negedge clk);
      end
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; m_axis_tready = 1'b0;
      n_total++; if (m_axis_tvalid !== 1'b0) $display("FAIL rstmid_tvalid: got %b want 0", m_axis_tvalid); else n_pass++;
      n_total++; if (fifo_level !== LW'(0)) $display("FAIL rstmid_level: got %0d want 0", fifo_level); else n_pass++;
      for (int i = 0; i < 4; i++) w[i] = $urandom();
      send_frame(w[0], w[1]);
      send_frame(w[2], w[3]);
      capture(5);
      n_total++;
      if (cap_n !== 5 || cap_data[0] !== 32'h0 || cap_data[1] !== w[0] || cap_data[4] !== w[3])
         $display("FAIL rstmid_next: got n=%0d %h %h %h want n=5 00000000 %h %h", cap_n, cap_data[0],
                  cap_data[1], cap_data[4], w[0], w[3]);
      else n_pass++;
   endtask

   // Model: accepted frames become an ordered word queue; packets of the latched length
   // are popped from it, each led by {seq, drop count at header time}.
   task automatic test_random();
      logic [31:0] expq [$];
      int          level, wpend, drop, cnt, len, waitc, idle_off, phase;
      logic [15:0] seq;
      logic [31:0] hdr_exp, prev_data;
      logic        prev_stall, prev_last, acc, lastexp;
      do_reset();
      cfg_enable = 1'b1; cfg_payload_words = PW'(3);
      level = 0; wpend = 0; drop = 0; cnt = 0; len = 0; waitc = 0; idle_off = 0; phase = 0;
      seq = '0; hdr_exp = '0; prev_data = '0; prev_stall = 1'b0; prev_last = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         n_total++;
         if (fifo_level !== LW'(level)) $display("FAIL rand_level@%0d: got %0d want %0d", cyc, fifo_level, level);
         else n_pass++;
         n_total++;
         if (drop_count !== 16'(drop)) $display("FAIL rand_drop@%0d: got %0d want %0d", cyc, drop_count, drop);
         else n_pass++;
         if (prev_stall) begin
            n_total++;
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev_data || m_axis_tlast !== prev_last)
               $display("FAIL rand_hold@%0d: got v=%b d=%h l=%b want v=1 d=%h l=%b", cyc, m_axis_tvalid,
                        m_axis_tdata, m_axis_tlast, prev_data, prev_last);
            else n_pass++;
         end
         if (phase == 0) begin
            if (m_axis_tvalid) begin
               phase = 1; len = clamp_len(int'(cfg_payload_words));
               hdr_exp = {seq, 16'(drop)};
            end else begin
               n_total++;
               if (waitc > 1) $display("FAIL rand_start@%0d: got tvalid=0 want 1 after %0d ready cycles", cyc, waitc);
               else n_pass++;
            end
         end
         s_sample_valid = ($urandom_range(0, 3) == 0);
         s_sample_data  = {$urandom(), $urandom()};
         m_axis_tready  = ($urandom_range(0, 3) != 0);
         if (phase != 0 && $urandom_range(0, 15) == 0) cfg_payload_words = PW'($urandom_range(0, 15));
         if (phase != 0 && $urandom_range(0, 15) == 0) cfg_enable = 1'($urandom_range(0, 1));
         if (phase == 0 && !cfg_enable) begin
            idle_off++;
            if (idle_off > 20) begin cfg_enable = 1'b1; idle_off = 0; end
         end
         if (phase == 0 && cfg_enable && level >= clamp_len(int'(cfg_payload_words))) waitc++;
         else waitc = 0;
         acc = s_sample_valid && (wpend == 0) && ((DEPTH - level) >= NCH);
         if (m_axis_tvalid && m_axis_tready) begin
            if (phase == 1) begin
               n_total++;
               if (m_axis_tdata !== hdr_exp || m_axis_tlast !== 1'b0)
                  $display("FAIL rand_header@%0d: got d=%h l=%b want d=%h l=0", cyc, m_axis_tdata,
                           m_axis_tlast, hdr_exp);
               else n_pass++;
               phase = 2; cnt = 0;
            end else if (phase == 2) begin
               lastexp = (cnt == len - 1);
               n_total++;
               if (expq.size() == 0 || m_axis_tdata !== expq[0] || m_axis_tlast !== lastexp)
                  $display("FAIL rand_payload@%0d: got d=%h l=%b want d=%h l=%b", cyc, m_axis_tdata,
                           m_axis_tlast, (expq.size() == 0) ? 32'hx : expq[0], lastexp);
               else n_pass++;
               if (expq.size() != 0) void'(expq.pop_front());
               cnt++; level--;
               if (cnt == len) begin phase = 0; seq = seq + 16'd1; end
            end
         end
         if (wpend > 0) begin level++; wpend--; end
         if (acc) begin
            expq.push_back(s_sample_data[31:0]);
            expq.push_back(s_sample_data[63:32]);
            wpend = NCH;
         end else if (s_sample_valid && drop < 16'hFFFF) begin
            drop++;
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_data  = m_axis_tdata;
         prev_last  = m_axis_tlast;
         @(negedge clk);
      end
      s_sample_valid = 1'b0; m_axis_tready = 1'b0;
   endtask

   initial begin
      rst_n = 1'b1; s_sample_valid = 1'b0; s_sample_data = '0;
      cfg_enable = 1'b0; cfg_payload_words = '0; m_axis_tready = 1'b0;
      test_reset();
      test_header_packet();
      test_backpressure();
      test_fifo_full();
      test_min_length();
      test_busy();
      test_midpacket();
      test_reset_midpacket();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
